// File: rtl/plic_scan_arbiter_if.sv
// Signal bundle between one PLIC target arbiter and its gateway/register block.
//   irq_pending_i : gateway pending vector, bit i is source ID i+1
//   irq_enable_i  : per-target enable bits
//   irq_prio_i    : per-source priority
//   threshold_i   : per-target priority threshold
//   claim_req_i   : one-cycle claim read strobe
//   claim_idx_o   : committed winner ID (0 = none)
//   max_prio_o    : committed winner priority
//   irq_o         : target interrupt request
//   scan_done_o   : one-cycle pulse on scan commit
// The slave modport is the arbiter side; master is the gateway/register side.
interface plic_scan_arbiter_if #(
  parameter int unsigned SOURCE_COUNT = 16,
  parameter int unsigned PRIO_WIDTH   = 3,
  parameter int unsigned SOURCE_WIDTH = $clog2(SOURCE_COUNT + 1)
);

  logic [SOURCE_COUNT-1:0]                 irq_pending_i;
  logic [SOURCE_COUNT-1:0]                 irq_enable_i;
  logic [SOURCE_COUNT-1:0][PRIO_WIDTH-1:0] irq_prio_i;
  logic [PRIO_WIDTH-1:0]                   threshold_i;
  logic                                    claim_req_i;
  logic [SOURCE_WIDTH-1:0]                 claim_idx_o;
  logic [PRIO_WIDTH-1:0]                   max_prio_o;
  logic                                    irq_o;
  logic                                    scan_done_o;

  modport master (
    output irq_pending_i,
    output irq_enable_i,
    output irq_prio_i,
    output threshold_i,
    output claim_req_i,
    input  claim_idx_o,
    input  max_prio_o,
    input  irq_o,
    input  scan_done_o
  );

  modport slave (
    input  irq_pending_i,
    input  irq_enable_i,
    input  irq_prio_i,
    input  threshold_i,
    input  claim_req_i,
    output claim_idx_o,
    output max_prio_o,
    output irq_o,
    output scan_done_o
  );

endinterface

// File: rtl/plic_scan_arbiter.sv
// Per-target PLIC arbiter. Scans one source per cycle, keeping a running best
// (strictly-greater priority replaces it, so ties go to the lower ID), and
// commits the result after the last source. A claim discards the outputs and
// restarts the scan from source 1.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : plic_scan_arbiter_if.slave (pending/enable/prio/threshold/claim in,
//          claim_idx/max_prio/irq/scan_done out, all outputs registered)
module plic_scan_arbiter #(
  parameter int unsigned SOURCE_COUNT = 16,
  parameter int unsigned PRIO_WIDTH   = 3,
  parameter int unsigned SOURCE_WIDTH = $clog2(SOURCE_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  plic_scan_arbiter_if.slave    bus
);

  // A single-source instance still needs a 1-bit index register.
  localparam int unsigned IDX_WIDTH = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1;
  localparam int unsigned LAST_IDX  = SOURCE_COUNT - 1;

  logic [IDX_WIDTH-1:0]    idx_q,       idx_d;
  logic [SOURCE_WIDTH-1:0] best_id_q,   best_id_d;
  logic [PRIO_WIDTH-1:0]   best_prio_q, best_prio_d;
  logic [SOURCE_WIDTH-1:0] claim_idx_q, claim_idx_d;
  logic [PRIO_WIDTH-1:0]   max_prio_q,  max_prio_d;
  logic                    irq_q,       irq_d;
  logic                    scan_done_q, scan_done_d;

  logic                    last_c;
  logic                    cand_c;
  logic [PRIO_WIDTH-1:0]   cur_prio_c;
  logic [SOURCE_WIDTH-1:0] run_id_c;
  logic [PRIO_WIDTH-1:0]   run_prio_c;
  logic [SOURCE_WIDTH-1:0] new_id_c;
  logic [PRIO_WIDTH-1:0]   new_prio_c;

  // Evaluate the source under the index against the running best.
  always_comb begin
    last_c     = (idx_q == IDX_WIDTH'(LAST_IDX));
    cur_prio_c = bus.irq_prio_i[idx_q];
    cand_c     = bus.irq_pending_i[idx_q] & bus.irq_enable_i[idx_q] &
                 (cur_prio_c != '0);

    // Index 0 always starts from a cleared best, regardless of leftovers.
    run_id_c   = (idx_q == '0) ? '0 : best_id_q;
    run_prio_c = (idx_q == '0) ? '0 : best_prio_q;

    new_id_c   = run_id_c;
    new_prio_c = run_prio_c;
    if (cand_c && (cur_prio_c > run_prio_c)) begin
      new_id_c   = SOURCE_WIDTH'(idx_q) + SOURCE_WIDTH'(1);
      new_prio_c = cur_prio_c;
    end
  end

  // Next-state: advance scan, commit on the last index, claim overrides all.
  always_comb begin
    idx_d       = last_c ? '0 : idx_q + IDX_WIDTH'(1);
    best_id_d   = new_id_c;
    best_prio_d = new_prio_c;
    claim_idx_d = claim_idx_q;
    max_prio_d  = max_prio_q;
    scan_done_d = 1'b0;

    if (last_c) begin
      claim_idx_d = new_id_c;
      max_prio_d  = new_prio_c;
      scan_done_d = 1'b1;
    end

    if (bus.claim_req_i) begin
      idx_d       = '0;
      best_id_d   = '0;
      best_prio_d = '0;
      claim_idx_d = '0;
      max_prio_d  = '0;
      scan_done_d = 1'b0;
    end

    // Uses the value being committed this edge and the live threshold.
    irq_d = (max_prio_d > bus.threshold_i) && (claim_idx_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      claim_idx_q <= '0;
      max_prio_q  <= '0;
      irq_q       <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      claim_idx_q <= claim_idx_d;
      max_prio_q  <= max_prio_d;
      irq_q       <= irq_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.claim_idx_o = claim_idx_q;
  assign bus.max_prio_o  = max_prio_q;
  assign bus.irq_o       = irq_q;
  assign bus.scan_done_o = scan_done_q;

endmodule

// File: tb/tb_plic_scan_arbiter.sv
// Bench for plic_scan_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a scan-position reference model.
module tb_plic_scan_arbiter;

  localparam int unsigned N  = 16;
  localparam int unsigned PW = 3;
  localparam int unsigned SW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plic_scan_arbiter_if #(.SOURCE_COUNT(N), .PRIO_WIDTH(PW), .SOURCE_WIDTH(SW)) bus ();

  plic_scan_arbiter #(.SOURCE_COUNT(N), .PRIO_WIDTH(PW), .SOURCE_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: source k is observed k cycles after a scan (re)start;
  // at the end of a scan the winner is the highest sampled priority, lowest ID.
  int m_pos;
  int m_claim;
  int m_prio;
  int m_irq;
  int m_done;
  int snap [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int best;
    int bid;
    if (rst) begin
      m_pos = 0; m_claim = 0; m_prio = 0; m_irq = 0; m_done = 0;
      return;
    end
    snap[m_pos] = (bus.irq_pending_i[m_pos] && bus.irq_enable_i[m_pos]) ?
                  int'(bus.irq_prio_i[m_pos]) : 0;
    m_done = 0;
    if (bus.claim_req_i) begin
      m_claim = 0; m_prio = 0; m_pos = 0;
    end else if (m_pos == N - 1) begin
      best = 0;
      for (int k = 0; k < N; k++) if (snap[k] > best) best = snap[k];
      bid = 0;
      if (best > 0)
        for (int k = N - 1; k >= 0; k--) if (snap[k] == best) bid = k + 1;
      m_claim = bid; m_prio = best; m_done = 1; m_pos = 0;
    end else begin
      m_pos++;
    end
    m_irq = ((m_prio > int'(bus.threshold_i)) && (m_claim != 0)) ? 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("claim_idx", 32'(bus.claim_idx_o), 32'(m_claim));
    check("max_prio",  32'(bus.max_prio_o),  32'(m_prio));
    check("irq",       32'(bus.irq_o),       32'(m_irq));
    check("scan_done", 32'(bus.scan_done_o), 32'(m_done));
  endtask

  task automatic clear_inputs();
    bus.irq_pending_i = '0;
    bus.irq_enable_i  = '0;
    bus.irq_prio_i    = '0;
    bus.threshold_i   = '0;
    bus.claim_req_i   = 1'b0;
  endtask

  task automatic set_src(input int id, input logic pend, input logic en, input int prio);
    bus.irq_pending_i[id-1] = pend;
    bus.irq_enable_i[id-1]  = en;
    bus.irq_prio_i[id-1]    = PW'(prio);
  endtask

  // Ticks until scan_done_o is seen; n = number of ticks taken.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.scan_done_o && n < budget);
    if (!bus.scan_done_o) check("scan_done_timeout", 32'(n), 32'(budget + 1));
  endtask

  // Two commits guarantee one full scan with the current inputs.
  task automatic settle();
    int n;
    wait_done(40, n);
    wait_done(40, n);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("rst_claim_idx", 32'(bus.claim_idx_o), 32'd0);
    check("rst_irq", 32'(bus.irq_o), 32'd0);

    // Reset in the middle of a scan (index 7), then restart latency.
    rst = 1'b0;
    set_src(1, 1'b1, 1'b1, 5);
    bus.threshold_i = 3'd1;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midscan_rst_claim", 32'(bus.claim_idx_o), 32'd0);
    wait_done(40, n);
    check("first_done_latency", 32'(n), 32'd16);
    check("first_done_claim", 32'(bus.claim_idx_o), 32'd1);

    // Single source 5, prio 3, threshold 1.
    clear_inputs();
    set_src(5, 1'b1, 1'b1, 3);
    bus.threshold_i = 3'd1;
    settle();
    check("s5_claim", 32'(bus.claim_idx_o), 32'd5);
    check("s5_prio", 32'(bus.max_prio_o), 32'd3);
    check("s5_irq", 32'(bus.irq_o), 32'd1);

    // Tie at prio 6 goes to the lower ID; disabling it promotes the other.
    clear_inputs();
    set_src(4, 1'b1, 1'b1, 6);
    set_src(9, 1'b1, 1'b1, 6);
    set_src(12, 1'b1, 1'b1, 2);
    settle();
    check("tie_claim", 32'(bus.claim_idx_o), 32'd4);
    bus.irq_enable_i[3] = 1'b0;
    settle();
    check("tie_disable_claim", 32'(bus.claim_idx_o), 32'd9);
    check("tie_disable_prio", 32'(bus.max_prio_o), 32'd6);

    // Threshold equal to priority masks irq; lowering it needs no rescan.
    clear_inputs();
    set_src(3, 1'b1, 1'b1, 2);
    bus.threshold_i = 3'd2;
    settle();
    check("thr_claim", 32'(bus.claim_idx_o), 32'd3);
    check("thr_irq_masked", 32'(bus.irq_o), 32'd0);
    bus.threshold_i = 3'd1;
    tick();
    check("thr_irq_open", 32'(bus.irq_o), 32'd1);
    check("thr_no_done", 32'(bus.scan_done_o), 32'd0);

    // Priority 0 never wins.
    clear_inputs();
    set_src(7, 1'b1, 1'b1, 0);
    settle();
    for (int i = 0; i < 20; i++) tick();
    check("prio0_claim", 32'(bus.claim_idx_o), 32'd0);
    check("prio0_irq", 32'(bus.irq_o), 32'd0);

    // Claim with winner 5: held during the strobe, cleared after.
    clear_inputs();
    set_src(5, 1'b1, 1'b1, 3);
    bus.threshold_i = 3'd1;
    settle();
    bus.claim_req_i = 1'b1;
    #1;
    check("claim_hold", 32'(bus.claim_idx_o), 32'd5);
    tick();
    bus.claim_req_i = 1'b0;
    check("claim_cleared", 32'(bus.claim_idx_o), 32'd0);
    check("claim_irq", 32'(bus.irq_o), 32'd0);
    wait_done(40, n);
    check("claim_restart_latency", 32'(n), 32'd16);

    // Claim in the commit cycle drops the commit.
    for (int i = 0; i < 15; i++) tick();
    bus.claim_req_i = 1'b1;
    tick();
    bus.claim_req_i = 1'b0;
    check("commit_claim_done", 32'(bus.scan_done_o), 32'd0);
    check("commit_claim_idx", 32'(bus.claim_idx_o), 32'd0);
    wait_done(40, n);
    check("commit_claim_latency", 32'(n), 32'd16);
    check("commit_claim_result", 32'(bus.claim_idx_o), 32'd5);

    // Back-to-back claims each restart the scan.
    bus.claim_req_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.claim_req_i = 1'b0;
    wait_done(40, n);
    check("multi_claim_latency", 32'(n), 32'd16);

    // Random traffic: inputs change every cycle, occasional claims and resets.
    for (int c = 0; c < 1500; c++) begin
      bus.irq_pending_i = N'($urandom);
      bus.irq_enable_i  = N'($urandom);
      for (int k = 0; k < N; k++) bus.irq_prio_i[k] = PW'($urandom);
      if ($urandom_range(0, 7) == 0) bus.threshold_i = PW'($urandom);
      bus.claim_req_i = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus.claim_req_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plic_scan_arbiter.md
Name: plic_scan_arbiter

Overview:
Per-target PLIC arbiter. It resolves the highest-priority pending, enabled interrupt source for one target and drives the target interrupt line and the claim ID. Instead of a wide combinational max-tree, it scans sources serially, one per cycle, for area. One instance sits between the gateway pending vector and the register block for each target. Its claim_idx_o feeds the gateway claim_idx_i slot for that target.

Parameters:
- SOURCE_COUNT, 16, number of interrupt sources; IDs run 1..SOURCE_COUNT and ID 0 means "no interrupt".
- PRIO_WIDTH, 3, width of each source priority and of the threshold.
- SOURCE_WIDTH, $clog2(SOURCE_COUNT+1), width of a source ID.

Ports:
- clk, input, 1, clock; all logic is rising-edge.
- rst, input, 1, synchronous active-high reset.
- irq_pending_i, input, SOURCE_COUNT, gateway pending vector; bit i is source ID i+1.
- irq_enable_i, input, SOURCE_COUNT, per-target enable bits.
- irq_prio_i, input, SOURCE_COUNT x PRIO_WIDTH, per-source priority.
- threshold_i, input, PRIO_WIDTH, per-target priority threshold.
- claim_req_i, input, 1, one-cycle claim read strobe from the register block.
- claim_idx_o, output, SOURCE_WIDTH, latched winner ID (0 if none).
- max_prio_o, output, PRIO_WIDTH, latched winner priority.
- irq_o, output, 1, target interrupt request.
- scan_done_o, output, 1, one-cycle pulse when a scan result is committed.

Behaviour:
- Reset: on clk edge with rst=1, clear everything.
  - scan index = 0, running best ID = 0, running best priority = 0.
  - claim_idx_o = 0, max_prio_o = 0, irq_o = 0, scan_done_o = 0.
  - Applies mid-scan; the partial result is discarded.
- Scan: free-running index counter 0..SOURCE_COUNT-1, one source per cycle.
  - Source i is a candidate if irq_pending_i[i] & irq_enable_i[i] & (irq_prio_i[i] != 0).
  - A candidate replaces the running best only if its priority is strictly greater than the running best priority.
  - Ties therefore go to the lower ID. Priority 0 never wins.
  - Index 0 starts from a cleared running best (ID 0, priority 0), evaluated the same cycle.
- Commit: in the cycle the index equals SOURCE_COUNT-1, the final running best is registered.
  - The next cycle shows it on claim_idx_o and max_prio_o, with scan_done_o = 1 for that one cycle.
  - The index wraps to 0 and the running best clears.
  - Full scan latency is SOURCE_COUNT cycles; result-to-output is 1 cycle after the last source is sampled.
- irq_o is registered: (max_prio_o > threshold_i) & (claim_idx_o != 0).
  - It is updated on the same edge as claim_idx_o, using the committed priority and the current threshold.
  - A threshold change alone is reflected on the next edge, with no rescan.
- Inputs are sampled only at scan time. A source that drops pending after commit keeps its committed result until the next commit or a claim.
- Claim: claim_req_i=1 in cycle T.
  - claim_idx_o holds its value throughout cycle T, so the gateway clears that source's pending bit.
  - On edge T+1: claim_idx_o = 0, max_prio_o = 0, irq_o = 0, index = 0, running best cleared (scan restarts from source 1).
  - The next valid result appears SOURCE_COUNT+1 cycles after T.
- Simultaneous claim and commit: claim wins. The commit is dropped, outputs go to 0 and the scan restarts; scan_done_o stays 0.
- Claim with claim_idx_o = 0: still restarts the scan; outputs stay 0.
- Consecutive claim strobes: each one restarts the scan.
- SOURCE_COUNT=1 is legal: every cycle is a commit cycle.

Test Plan:
- Reset mid-scan (index 7), then release -> outputs 0. The first scan_done_o arrives 16 cycles after release, and the index restarts at 0.
- Source 5 pending+enabled, prio 3, threshold 1 -> after one full scan: claim_idx_o=5, max_prio_o=3, irq_o=1.
- Sources 4 and 9 both at prio 6, source 12 at prio 2 -> claim_idx_o=4. Then disable 4 -> after the next commit, claim_idx_o=9.
- Source 3 at prio 2 with threshold 2 -> claim_idx_o=3, irq_o=0. Set threshold 1 -> irq_o=1 on the next edge, with no scan_done_o.
- Source 7 at prio 0 pending+enabled, all others idle -> claim_idx_o=0, irq_o=0 forever.
- Claim with winner 5 -> claim_idx_o=5 during the strobe, then 0 the next cycle, irq_o=0. Claim in the commit cycle -> scan_done_o stays 0 and outputs stay 0 until the next full scan.
